// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: state codes,
// PC-source selects, trap causes and the post-retire next-state helper.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_TRAP   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL   = 2'd0,
        CAUSE_IFETCH_TO = 2'd1,
        CAUSE_DMEM_TO   = 2'd2
    } cause_e;

    // After an instruction retires or traps, keep going only while run is high.
    function automatic state_e after_retire(input logic run);
        if (run) begin
            return FETCH;
        end else begin
            return IDLE;
        end
    endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Handshake/strobe bundle between the sequencer (master) and the
// memories, control unit and PC/regfile datapath (slave).
interface multicycle_seq_if #(parameter int CNT_W = 64);
    logic             run;
    logic             imem_req, imem_ready, ir_write;
    logic             cu_reg_write, cu_mem_read, cu_mem_write;
    logic             cu_branch, cu_jump, cu_csr_write_enable, cu_illegal;
    logic             branch_taken;
    logic             dmem_req, dmem_we, dmem_ready;
    logic             rf_we, csr_we, pc_write;
    logic [1:0]       pc_sel;
    logic             trap;
    logic [1:0]       trap_cause;
    logic             instret;
    logic [2:0]       state;
    logic [CNT_W-1:0] mcycle, minstret;

    modport master (
        input  run, imem_ready, cu_reg_write, cu_mem_read, cu_mem_write,
               cu_branch, cu_jump, cu_csr_write_enable, cu_illegal,
               branch_taken, dmem_ready,
        output imem_req, ir_write, dmem_req, dmem_we, rf_we, csr_we, pc_write,
               pc_sel, trap, trap_cause, instret, state, mcycle, minstret
    );

    modport slave (
        output run, imem_ready, cu_reg_write, cu_mem_read, cu_mem_write,
               cu_branch, cu_jump, cu_csr_write_enable, cu_illegal,
               branch_taken, dmem_ready,
        input  imem_req, ir_write, dmem_req, dmem_we, rf_we, csr_we, pc_write,
               pc_sel, trap, trap_cause, instret, state, mcycle, minstret
    );
endinterface

// File: rtl/seq_wdog.sv
// Memory-wait watchdog: counts stalled cycles and flags expiry when the
// count reaches TIMEOUT. TIMEOUT=0 disables expiry altogether.
module seq_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    // Next count: clear wins, saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (count && (TIMEOUT != 0) && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP control.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_seq_if.master   bus
);
    state_e  state_q, state_d;
    cause_e  cause_q, cause_d;
    pc_sel_e pc_sel_s;
    logic    imem_req_s, ir_write_s, dmem_req_s, dmem_we_s;
    logic    rf_we_s, csr_we_s, pc_write_s, trap_s, instret_s;
    logic    wd_clear_s, wd_count_s, wd_expired_s;

    // Any state change restarts the wait count, so FETCH and MEM always begin at zero.
    assign wd_clear_s = (state_d != state_q);

    seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_s),
        .count   (wd_count_s),
        .expired (wd_expired_s)
    );

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_s = 1'b0;
        ir_write_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        rf_we_s    = 1'b0;
        csr_we_s   = 1'b0;
        pc_write_s = 1'b0;
        pc_sel_s   = PC_PLUS4;
        trap_s     = 1'b0;
        instret_s  = 1'b0;
        wd_count_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                imem_req_s = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_s = 1'b1;
                    state_d    = DECODE;
                end else if (wd_expired_s) begin
                    state_d = TRAP;
                    cause_d = CAUSE_IFETCH_TO;
                end else begin
                    wd_count_s = 1'b1;
                end
            end
            DECODE: begin
                if (bus.cu_illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.cu_mem_read || bus.cu_mem_write) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = bus.cu_mem_write;
                if (bus.dmem_ready) begin
                    // Stores have nothing to write back, so they retire here.
                    if (bus.cu_mem_write) begin
                        pc_write_s = 1'b1;
                        instret_s  = 1'b1;
                        state_d    = after_retire(bus.run);
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_expired_s) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end else begin
                    wd_count_s = 1'b1;
                end
            end
            WB: begin
                rf_we_s    = bus.cu_reg_write;
                csr_we_s   = bus.cu_csr_write_enable;
                pc_write_s = 1'b1;
                instret_s  = 1'b1;
                if (bus.cu_jump || (bus.cu_branch && bus.branch_taken)) begin
                    pc_sel_s = PC_TARGET;
                end else begin
                    pc_sel_s = PC_PLUS4;
                end
                state_d = after_retire(bus.run);
            end
            TRAP: begin
                trap_s     = 1'b1;
                pc_write_s = 1'b1;
                pc_sel_s   = PC_TRAP;
                state_d    = after_retire(bus.run);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= CAUSE_ILLEGAL;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign bus.imem_req   = imem_req_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.dmem_req   = dmem_req_s;
    assign bus.dmem_we    = dmem_we_s;
    assign bus.rf_we      = rf_we_s;
    assign bus.csr_we     = csr_we_s;
    assign bus.pc_write   = pc_write_s;
    assign bus.pc_sel     = pc_sel_s;
    assign bus.trap       = trap_s;
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_s;
    assign bus.state      = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    // Counter increments; both wrap naturally at 2^CNT_W.
    always_comb begin
        mcycle_d = mcycle_q + CNT_W'(1);
        if (instret_s) begin
            minstret_d = minstret_q + CNT_W'(1);
        end else begin
            minstret_d = minstret_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= {CNT_W{1'b0}};
            minstret_q <= {CNT_W{1'b0}};
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign bus.mcycle   = mcycle_q;
    assign bus.minstret = minstret_q;
`else
    assign bus.mcycle   = {CNT_W{1'b0}};
    assign bus.minstret = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: an instruction-level model schedules
// memory/CU stimulus and queues the expected per-cycle state and retire/trap events.
module tb_multicycle_seq;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3,
                   K_JUMP = 4, K_CSR = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_seq_if #(.CNT_W(CNT_W)) bus();
    multicycle_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [2:0] st;
        logic ireq, dreq, dwe, irw, ev;
    } cyc_t;
    typedef struct {
        int         at;
        logic       trap;
        logic [1:0] cause;
        logic [1:0] psel;
        logic       rf, csr, ret;
    } ev_t;

    cyc_t cq[$];
    ev_t  eq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   n_ret = 0;
    logic [1:0] last_cause = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle state trace and retire/trap event scoreboard.
    always @(negedge clk) begin
        cyc_t c;
        ev_t  e;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("state", 64'(bus.state), 64'(c.st));
            chk("imem_req", 64'(bus.imem_req), 64'(c.ireq));
            chk("ir_write", 64'(bus.ir_write), 64'(c.irw));
            chk("dmem_req", 64'(bus.dmem_req), 64'(c.dreq));
            if (c.dreq) chk("dmem_we", 64'(bus.dmem_we), 64'(c.dwe));
            if (!c.ev) chk("quiet_strobes",
                           64'({bus.rf_we, bus.csr_we, bus.pc_write, bus.trap, bus.instret}), 64'(0));
        end
        if (eq.size() > 0 && eq[0].at < cyc) begin
            e = eq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: expected pc_write at cyc %0d, still absent at %0d", e.at, cyc);
        end
        if (bus.pc_write) begin
            if (eq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pc_write @cyc %0d: got 1 expected 0", cyc);
            end else begin
                e = eq.pop_front();
                chk("ev_cycle", 64'(cyc), 64'(e.at));
                chk("trap", 64'(bus.trap), 64'(e.trap));
                chk("trap_cause", 64'(bus.trap_cause), 64'(e.cause));
                chk("pc_sel", 64'(bus.pc_sel), 64'(e.psel));
                chk("rf_we", 64'(bus.rf_we), 64'(e.rf));
                chk("csr_we", 64'(bus.csr_we), 64'(e.csr));
                chk("instret", 64'(bus.instret), 64'(e.ret));
            end
        end
        if (bus.trap) chk("rf_csr_with_trap", 64'({bus.rf_we, bus.csr_we}), 64'(0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic ireq, input logic dreq,
                        input logic dwe, input logic irw, input logic ev);
        cq.push_back('{st, ireq, dreq, dwe, irw, ev});
    endtask

    task automatic push_ev(input logic trap, input logic [1:0] cause, input logic [1:0] psel,
                           input logic rf, input logic csr, input logic ret);
        eq.push_back('{cyc, trap, cause, psel, rf, csr, ret});
    endtask

    task automatic trap_ev(input logic [1:0] cause);
        last_cause = cause;
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_ev(1'b1, cause, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    // n IDLE cycles with run low except in the last, which starts the next fetch.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.run = (i == n - 1);
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    // Entered in the first FETCH cycle; wi/wd are memory wait cycles.
    task automatic do_instr(input int kind, input int wi, input int wd, input logic taken,
                            input logic run_v, input logic abort);
        logic rw, ld, st, br, jp, cs, il, ev;
        int   nf, nm;
        rw = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP) || (kind == K_CSR);
        ld = (kind == K_LOAD);
        st = (kind == K_STORE);
        br = (kind == K_BRANCH);
        jp = (kind == K_JUMP);
        cs = (kind == K_CSR);
        il = (kind == K_ILL);
        bus.cu_reg_write = rw; bus.cu_mem_read = ld; bus.cu_mem_write = st;
        bus.cu_branch = br; bus.cu_jump = jp; bus.cu_csr_write_enable = cs;
        bus.cu_illegal = il; bus.branch_taken = taken; bus.run = run_v;

        nf = (wi > TIMEOUT) ? TIMEOUT + 1 : wi + 1;
        for (int j = 0; j < nf; j++) begin
            bus.imem_ready = (j == wi);
            push(3'd1, 1'b1, 1'b0, 1'b0, (j == wi), 1'b0);
            step();
        end
        bus.imem_ready = 1'b0;
        if (wi > TIMEOUT) begin
            trap_ev(2'd1);
            return;
        end
        push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (il) begin
            trap_ev(2'd0);
            return;
        end
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (ld || st) begin
            nm = (wd > TIMEOUT) ? TIMEOUT + 1 : wd + 1;
            for (int j = 0; j < nm; j++) begin
                if (abort && j == 1) begin
                    rst_n = 1'b0;
                    bus.dmem_ready = 1'b0;
                    bus.run = 1'b0;
                    #1;
                    chk("abort_dmem_req", 64'(bus.dmem_req), 64'(0));
                    chk("abort_state", 64'(bus.state), 64'(0));
                    chk("abort_pc_write", 64'(bus.pc_write), 64'(0));
                    return;
                end
                bus.dmem_ready = (j == wd);
                ev = st && (j == wd);
                push(3'd4, 1'b0, 1'b1, st, 1'b0, ev);
                if (ev) begin
                    push_ev(1'b0, last_cause, 2'd0, 1'b0, 1'b0, 1'b1);
                    n_ret++;
                end
                step();
            end
            bus.dmem_ready = 1'b0;
            if (wd > TIMEOUT) begin
                trap_ev(2'd2);
                return;
            end
            if (st) return;
        end
        push(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_ev(1'b0, last_cause, (jp || (br && taken)) ? 2'd1 : 2'd0, rw, cs, 1'b1);
        n_ret++;
        step();
    endtask

    task automatic check_counters(input string tag);
        logic [CNT_W-1:0] exp_mc, exp_mi;
`ifdef SEQ_PERF_CNT_EN
        exp_mc = CNT_W'(cyc - rel_cyc);
        exp_mi = CNT_W'(n_ret);
`else
        exp_mc = {CNT_W{1'b0}};
        exp_mi = {CNT_W{1'b0}};
`endif
        chk({tag, "_mcycle"}, 64'(bus.mcycle), 64'(exp_mc));
        chk({tag, "_minstret"}, 64'(bus.minstret), 64'(exp_mi));
    endtask

    task automatic release_reset();
        step();
        rst_n = 1'b1;
        rel_cyc = cyc;
        n_ret = 0;
        last_cause = 2'd0;
        chk("rst_state", 64'(bus.state), 64'(0));
        chk("rst_strobes", 64'({bus.imem_req, bus.dmem_req, bus.ir_write, bus.rf_we, bus.csr_we,
                                bus.pc_write, bus.trap, bus.instret}), 64'(0));
        chk("rst_pc_sel", 64'(bus.pc_sel), 64'(0));
        chk("rst_trap_cause", 64'(bus.trap_cause), 64'(0));
        chk("rst_mcycle", 64'(bus.mcycle), 64'(0));
        chk("rst_minstret", 64'(bus.minstret), 64'(0));
    endtask

    initial begin
        int k, wi, wd;
        logic tk, rv;
        rst_n = 1'b0;
        bus.run = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.cu_reg_write = 1'b0; bus.cu_mem_read = 1'b0; bus.cu_mem_write = 1'b0;
        bus.cu_branch = 1'b0; bus.cu_jump = 1'b0; bus.cu_csr_write_enable = 1'b0;
        bus.cu_illegal = 1'b0; bus.branch_taken = 1'b0;
        step();
        step();
        release_reset();
        idle(1);

        do_instr(K_ALU,    0, 0, 1'b0, 1'b1, 1'b0);   // ADD
        do_instr(K_LOAD,   0, 3, 1'b0, 1'b1, 1'b0);   // LW, 3 wait cycles
        do_instr(K_STORE,  0, 0, 1'b0, 1'b1, 1'b0);   // SW
        do_instr(K_BRANCH, 0, 0, 1'b1, 1'b1, 1'b0);   // BEQ taken
        do_instr(K_ILL,    0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(K_ALU,   99, 0, 1'b0, 1'b1, 1'b0);   // ifetch timeout
        do_instr(K_ALU, TIMEOUT, 0, 1'b0, 1'b1, 1'b0); // ready at the limit wins
        do_instr(K_LOAD,   0, TIMEOUT + 1, 1'b0, 1'b1, 1'b0); // dmem timeout
        do_instr(K_STORE,  1, TIMEOUT, 1'b0, 1'b1, 1'b0);
        do_instr(K_JUMP,   0, 0, 1'b0, 1'b0, 1'b0);   // run drops mid-instruction
        idle(3);
        do_instr(K_CSR,    2, 0, 1'b0, 1'b1, 1'b0);
        do_instr(K_BRANCH, 0, 0, 1'b0, 1'b1, 1'b0);   // BEQ not taken

        for (int i = 0; i < 40; i++) begin
            k  = int'($urandom_range(0, 6));
            wi = int'($urandom_range(0, TIMEOUT + 1));
            wd = int'($urandom_range(0, TIMEOUT + 1));
            tk = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 7) != 0);
            do_instr(k, wi, wd, tk, rv, 1'b0);
            if (!rv) idle(int'($urandom_range(1, 3)));
        end
        check_counters("run");

        // Reset in the middle of a data access.
        do_instr(K_LOAD, 0, 3, 1'b0, 1'b1, 1'b1);
        step();
        release_reset();
        idle(1);
        do_instr(K_ALU,   0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(K_STORE, 0, 1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check_counters("final");
        chk("cycle_queue_drained", 64'(cq.size()), 64'(0));
        chk("event_queue_drained", 64'(eq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
